pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Controls the PLL from the other side of its rst/locked interface. It pulses the PLL reset, waits for and qualifies `locked`, and only then releases the downstream system reset. Lock loss, lock timeout and retry exhaustion are handled autonomously. It runs on the free-running 24 MHz reference clock, which is never a PLL output, and sits between the PLL wrapper and all reset consumers in the top level.

Parameters:
RST_PULSE_CYCLES, 24, PLL reset assertion length in clk cycles (1 us); must be ≥1.
LOCK_SETTLE_CYCLES, 2400, consecutive locked-high cycles required before release (100 us); must be ≥1.
LOCK_TIMEOUT_CYCLES, 240000, max cycles to wait for lock after a reset pulse (10 ms); must be ≥1.
MAX_RETRIES, 7, PLL reset retries allowed before declaring failure; range 0..15.

Ports:
clk  in  1  free-running reference clock (24 MHz, not PLL-derived)
rst_n  in  1  asynchronous active-low reset
locked_in  in  1  PLL locked, asynchronous to clk
relock_req  in  1  single-cycle synchronous pulse; forces a full relock sequence
pll_rst  out  1  active-high reset to PLL
sys_rst_n  out  1  active-low downstream reset, registered
pll_ok  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_count  out  4  PLL reset pulses issued since last entry to RUN/FAIL-clear, saturating at 15

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All outputs registered.
- Reset values: pll_rst=1, sys_rst_n=0, pll_ok=0, fail=0, retry_count=0, state=PRST, counter=0.
- locked_in passes through a 2-FF synchronizer to give locked_s (2 clk latency). All decisions use locked_s only.
- One shared down-counter, wide enough for the largest of the three cycle parameters, reloaded on every state entry.
- PRST: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WLOCK.
- WLOCK: pll_rst=0.
  - locked_s=1 → go to SETTLE.
  - After LOCK_TIMEOUT_CYCLES cycles without lock: if retry_count<MAX_RETRIES, increment retry_count and go to PRST; else go to FAIL.
- SETTLE: requires locked_s=1 for LOCK_SETTLE_CYCLES consecutive cycles, then go to RUN.
  - Any locked_s=0 → back to WLOCK. The timeout restarts; no retry is consumed.
- RUN: sys_rst_n=1 and pll_ok=1 from the first RUN cycle. retry_count clears on entry.
- Lock loss in RUN: on the first cycle locked_s=0 is seen, the next edge drives sys_rst_n=0 and pll_ok=0, and the state moves to PRST.
- FAIL: fail=1, pll_rst=1 held, sys_rst_n=0. Exits only via relock_req or rst_n.
- relock_req in any state: next state PRST, retry_count=0, sys_rst_n=0, fail=0.
  - relock_req has priority over every other transition in the same cycle, including timeout and lock loss.
- sys_rst_n is 0 in every state except RUN.
- Mid-operation rst_n assertion returns all outputs to reset values immediately (asynchronous).

Optional Feature:
LOCK_GLITCH_FILTER_EN
- Defined: in RUN, lock loss is acted on only after locked_s=0 for 4 consecutive cycles. Shorter low glitches are ignored, and the filter count resets whenever locked_s=1. Lock-loss latency becomes 2+4 cycles from the locked_in fall.
- Undefined: any single low cycle of locked_s in RUN triggers lock-loss handling.
- SETTLE behaviour is the same in both builds.

Decomposition:
- Package pll_sup_pkg: state enum (PRST, WLOCK, SETTLE, RUN, FAIL), the glitch-filter depth constant (4), and a function returning the counter width from the three parameters.
- Sub-module sync_2ff: generic 2-flop synchronizer, reset to 0, reusable for other async status inputs.

Test Plan:
Test parameters: RST_PULSE_CYCLES=4, LOCK_SETTLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Release rst_n, raise locked_in 10 cycles after pll_rst falls → pll_rst high exactly 4 cycles; sys_rst_n rises 2+1+8 cycles after the locked_in rise (sync, WLOCK exit, settle); retry_count=0.
2. Hold locked_in=0 → three pll_rst pulses of 4 cycles each, 32-cycle gaps between them; retry_count goes 1, 2; then fail=1 and pll_rst stuck high. relock_req clears fail and restarts the sequence.
3. In SETTLE, drop locked_in for 1 cycle at settle count 5 → returns to WLOCK; retry_count unchanged; full 8-cycle settle is required again.
4. In RUN, drop locked_in for 1 cycle → sys_rst_n falls 3 cycles later and pll_rst pulses (filter off). With LOCK_GLITCH_FILTER_EN, no reaction to a 3-cycle drop; reaction to a 4-cycle drop.
5. Assert relock_req in the same cycle as a WLOCK timeout → PRST entered, retry_count=0 (not incremented).
6. Assert rst_n low mid-SETTLE → all outputs reach reset values without a clk edge.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PRST,
    WLOCK,
    SETTLE,
    RUN,
    FAIL
  } pll_state_t;

  localparam int GLITCH_FILTER_DEPTH = 4;

  // Bits needed to hold the largest of the three cycle parameters
  function automatic int counter_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous status inputs; resets to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock and gates the downstream system reset.
// Optional build macro LOCK_GLITCH_FILTER_EN: ignore lock drops shorter than 4 cycles in RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 24,
  parameter int LOCK_SETTLE_CYCLES  = 2400,
  parameter int LOCK_TIMEOUT_CYCLES = 240000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked_in,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ok,
  output logic       fail,
  output logic [3:0] retry_count
);

  localparam int CNT_W = counter_width(RST_PULSE_CYCLES, LOCK_SETTLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(LOCK_SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);

  logic             locked_s;
  pll_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       retry_d;
  logic             lock_lost;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked_in),
    .q     (locked_s)
  );

`ifdef LOCK_GLITCH_FILTER_EN
  localparam int LOW_W = $clog2(GLITCH_FILTER_DEPTH);
  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(GLITCH_FILTER_DEPTH - 1);
  logic [LOW_W-1:0] low_cnt, low_cnt_d;

  always_comb begin
    lock_lost = !locked_s && (low_cnt == LOW_LAST);
    low_cnt_d = (state == RUN && !locked_s && !lock_lost) ? low_cnt + 1'b1 : '0;
  end
`else
  assign lock_lost = !locked_s;
`endif

  // Counter holds cycles remaining in the current state; zero only right after
  // reset, where the first PRST cycle counts as the first of the pulse.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    retry_d = retry_count;
    case (state)
      PRST: begin
        if (cnt == CNT_ONE || (cnt == '0 && RST_PULSE_CYCLES == 1)) begin
          state_d = WLOCK;
          cnt_d   = TMO_LOAD;
        end else if (cnt == '0) begin
          cnt_d = RST_LOAD - 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      WLOCK: begin
        if (locked_s) begin
          state_d = SETTLE;
          cnt_d   = SET_LOAD;
        end else if (cnt <= CNT_ONE) begin
          if (retry_count < MAX_R) begin
            retry_d = retry_count + 1'b1;
            state_d = PRST;
            cnt_d   = RST_LOAD;
          end else begin
            state_d = FAIL;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_d = WLOCK;
          cnt_d   = TMO_LOAD;
        end else if (cnt <= CNT_ONE) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RUN: begin
        if (lock_lost) begin
          state_d = PRST;
          cnt_d   = RST_LOAD;
        end
      end
      FAIL: ;
      default: begin
        state_d = PRST;
        cnt_d   = RST_LOAD;
      end
    endcase
    if (relock_req) begin
      state_d = PRST;
      cnt_d   = RST_LOAD;
      retry_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PRST;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      pll_ok      <= 1'b0;
      fail        <= 1'b0;
`ifdef LOCK_GLITCH_FILTER_EN
      low_cnt     <= '0;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      retry_count <= retry_d;
      pll_rst     <= (state_d == PRST) || (state_d == FAIL);
      sys_rst_n   <= (state_d == RUN);
      pll_ok      <= (state_d == RUN);
      fail        <= (state_d == FAIL);
`ifdef LOCK_GLITCH_FILTER_EN
      low_cnt     <= low_cnt_d;
`endif
    end
  end

endmodule
